// File: rtl/iir_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iir_pkg
// Description : Shared word-width constants and sample type for the IIR chain.
// Revision    : 1.0
// ============================================================================
package iir_pkg;
    localparam int NB = 12;
    localparam int DW = NB + 1;

    typedef logic [DW-1:0] sample_t;
endpackage : iir_pkg
`default_nettype wire

// File: rtl/iir_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : iir_fifo_mem
// Description : DEPTH x DW register array, one write port, async read port.
// Revision    : 1.0
// ============================================================================
module iir_fifo_mem
    import iir_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int DW    = iir_pkg::DW
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [DW-1:0]            i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [DW-1:0]            o_rdata
);
    logic [DW-1:0] r_mem [DEPTH];

    // Storage is deliberately left unreset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule : iir_fifo_mem
`default_nettype wire

// File: rtl/iir_out_fifo.sv
`default_nettype none
// ============================================================================
// Module      : iir_out_fifo
// Description : Show-ahead output FIFO behind iir_filter with sticky overflow.
// Revision    : 1.0
// ============================================================================
module iir_out_fifo
    import iir_pkg::*;
#(
    parameter int NB    = iir_pkg::NB,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   vIn,
    input  logic [NB:0]            dIn,
    input  logic                   rdy,
    output logic                   vOut,
    output logic [NB:0]            dOut,
    output logic [$clog2(DEPTH):0] count,
    output logic                   ovf,
    input  logic                   ovf_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_ONE      = (AW+1)'(1);
    localparam logic [AW:0] c_FULL_XOR = c_ONE << AW;

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [AW:0] r_count;
    logic        r_vout;
    logic        r_ovf;

    logic        w_full;
    logic        w_rd;
    logic        w_wr;
    logic        w_drop;
    logic [AW:0] w_wr_ptr_nx;
    logic [AW:0] w_rd_ptr_nx;
    logic [AW:0] w_count_nx;
    logic [NB:0] w_rdata;

    // Full when the indices match but the wrap bits differ.
    assign w_full = ((r_wr_ptr ^ r_rd_ptr) == c_FULL_XOR);
    assign w_rd   = r_vout & rdy;
    assign w_wr   = vIn & (~w_full | w_rd);
    assign w_drop = vIn & w_full & ~rdy;

    always_comb begin
        w_wr_ptr_nx = r_wr_ptr;
        w_rd_ptr_nx = r_rd_ptr;
        w_count_nx  = r_count;
        if (w_wr) begin
            w_wr_ptr_nx = r_wr_ptr + c_ONE;
        end
        if (w_rd) begin
            w_rd_ptr_nx = r_rd_ptr + c_ONE;
        end
        case ({w_wr, w_rd})
            2'b10:   w_count_nx = r_count + c_ONE;
            2'b01:   w_count_nx = r_count - c_ONE;
            default: w_count_nx = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_vout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nx;
            r_rd_ptr <= w_rd_ptr_nx;
            r_count  <= w_count_nx;
            r_vout   <= (w_count_nx != '0);
            // A drop in the same cycle as a clear keeps the flag set.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    iir_fifo_mem #(
        .DEPTH (DEPTH),
        .DW    (NB + 1)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (dIn),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_rdata)
    );

    assign vOut  = r_vout;
    assign dOut  = r_vout ? w_rdata : '0;
    assign count = r_count;
    assign ovf   = r_ovf;
endmodule : iir_out_fifo
`default_nettype wire

// File: tb/tb_iir_out_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_iir_out_fifo
// Description : Queue-model bench with directed scenarios and random traffic.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_iir_out_fifo;
    import iir_pkg::*;

    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH);

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          vIn     = 1'b0;
    logic          rdy     = 1'b0;
    logic          ovf_clr = 1'b0;
    logic [NB:0]   dIn     = '0;
    logic          vOut;
    logic          ovf;
    logic [NB:0]   dOut;
    logic [AW:0]   count;

    int            checks = 0;
    int            errors = 0;

    sample_t       mq[$];
    logic          m_ovf     = 1'b0;
    bit            m_full;
    bit            m_rd;
    bit            cmp_en    = 1'b0;
    bit            seen_1fff = 1'b0;

    always #5 clk = ~clk;

    iir_out_fifo #(
        .NB    (NB),
        .DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .vIn     (vIn),
        .dIn     (dIn),
        .rdy     (rdy),
        .vOut    (vOut),
        .dOut    (dOut),
        .count   (count),
        .ovf     (ovf),
        .ovf_clr (ovf_clr)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: a bounded queue updated from the rules of one clock edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            m_full = (mq.size() == DEPTH);
            m_rd   = (mq.size() != 0) && rdy;
            if (vIn && m_full && !rdy) m_ovf = 1'b1;
            else if (ovf_clr)          m_ovf = 1'b0;
            if (m_rd) void'(mq.pop_front());
            if (vIn && (!m_full || m_rd)) mq.push_back(dIn);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("vOut",  vOut,  mq.size() != 0);
            chk("dOut",  dOut,  (mq.size() != 0) ? mq[0] : sample_t'(0));
            chk("count", count, mq.size());
            chk("ovf",   ovf,   m_ovf);
            if (vOut && rdy && dOut == sample_t'(13'h1FFF)) seen_1fff = 1'b1;
        end
    end

    // Inputs change 1 ns after the rising edge; returns 1 ns after the next one.
    task automatic tick(input logic v, input sample_t d, input logic r, input logic c);
        vIn = v; dIn = d; rdy = r; ovf_clr = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] r32;
        int          rdy_pct;

        cmp_en = 1'b1;
        for (int i = 0; i < 3; i++) tick(i[0], sample_t'(13'h0AB), 1'b1, 1'b0);
        chk("rst_vOut",  vOut,  0);
        chk("rst_count", count, 0);
        chk("rst_ovf",   ovf,   0);
        chk("rst_dOut",  dOut,  0);
        rst_n = 1'b1;
        tick(1'b0, '0, 1'b0, 1'b0);
        chk("rst_nothing_stored", vOut, 0);

        for (int i = 1; i <= 20; i++) begin
            tick(1'b1, sample_t'(i), 1'b1, 1'b0);
            chk("stream_dOut",  dOut,  i);
            chk("stream_count", count, 1);
        end
        tick(1'b0, '0, 1'b1, 1'b0);
        chk("stream_empty", vOut, 0);

        for (int i = 0; i < 8; i++) tick(1'b1, sample_t'(13'h100 + i), 1'b0, 1'b0);
        chk("fill_count", count, 8);
        chk("fill_head",  dOut,  13'h100);
        tick(1'b0, '0, 1'b0, 1'b0);
        chk("stall_hold", dOut, 13'h100);

        tick(1'b1, sample_t'(13'h1FFF), 1'b0, 1'b0);
        chk("ovf_set",   ovf,   1);
        chk("ovf_count", count, 8);
        chk("ovf_head",  dOut,  13'h100);
        tick(1'b0, '0, 1'b0, 1'b1);
        chk("ovf_clr", ovf, 0);
        tick(1'b1, sample_t'(13'h1FFF), 1'b0, 1'b1);
        chk("ovf_set_wins", ovf, 1);
        tick(1'b0, '0, 1'b0, 1'b1);
        chk("ovf_clr2", ovf, 0);

        tick(1'b1, sample_t'(13'h0AA), 1'b1, 1'b0);
        chk("full_rw_count", count, 8);
        chk("full_rw_ovf",   ovf,   0);
        chk("full_rw_head",  dOut,  13'h101);
        for (int j = 0; j < 7; j++) tick(1'b0, '0, 1'b1, 1'b0);
        chk("full_rw_last", dOut, 13'h0AA);
        tick(1'b0, '0, 1'b1, 1'b0);
        chk("drain_empty", vOut, 0);
        chk("dropped_never_out", seen_1fff, 0);

        for (int i = 0; i < 5; i++) tick(1'b1, sample_t'(13'h200 + i), 1'b0, 1'b0);
        chk("mid_count", count, 5);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vOut",  vOut,  0);
        chk("mid_rst_count", count, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(1'b1, sample_t'(13'h055), 1'b0, 1'b0);
        chk("post_rst_head",  dOut,  13'h055);
        chk("post_rst_count", count, 1);
        tick(1'b0, '0, 1'b1, 1'b0);

        for (int p = 0; p < 6; p++) begin
            rdy_pct = p[0] ? 20 : 80;
            for (int k = 0; k < 120; k++) begin
                r32 = $urandom();
                tick($urandom_range(0, 3) != 0, r32[NB:0],
                     $urandom_range(0, 99) < rdy_pct, $urandom_range(0, 15) == 0);
            end
        end

        for (int k = 0; k < DEPTH + 2; k++) tick(1'b0, '0, 1'b1, 1'b0);
        chk("final_empty", vOut, 0);
        cmp_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule : tb_iir_out_fifo
`default_nettype wire
